alu_seq: RTL and testbench

Parametrised, registered arithmetic-logic unit with a start/done handshake. Single-cycle logic and add/subtract operations complete in one clock. Multiply (shift-add) and divide (restoring) run iteratively over W cycles. Sits between the register file and the datapath controller, and replaces the 1-bit combinational ALU in wider datapaths.

---
 rtl/alu_seq.sv | 158 +++++++++++++++
 tb/tb_alu_seq.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered W-bit ALU with start/done handshake: logic/add/sub/SLT finish in one
// clock, MUL (shift-add) and DIV (restoring) iterate for W clocks in the ITER state.
module alu_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   codigo,
    input  logic [W-1:0] OP1,
    input  logic [W-1:0] OP2,
    output logic [W-1:0] res,
    output logic [W-1:0] res_hi,
    output logic         zero,
    output logic         carry,
    output logic         ovf,
    output logic         div0,
    output logic         busy,
    output logic         done
);
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic {IDLE, ITER} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          is_div_q;
    logic [W-1:0]  opb_q;
    logic [W-1:0]  acc_hi_q, acc_lo_q;
    logic [W-1:0]  res_q, res_hi_q;
    logic          zero_q, carry_q, ovf_q, div0_q, busy_q, done_q;

    // Single-cycle results are computed straight from the operand inputs
    logic [W:0]    sum, dif;
    logic [W-1:0]  sc_res;
    logic          sc_carry, sc_ovf;

    always_comb begin
        sum      = {1'b0, OP1} + {1'b0, OP2};
        dif      = {1'b0, OP1} - {1'b0, OP2};
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        case (codigo)
            3'b000: begin
                sc_res   = sum[W-1:0];
                sc_carry = sum[W];
                sc_ovf   = (OP1[W-1] == OP2[W-1]) && (sum[W-1] != OP1[W-1]);
            end
            3'b001: begin
                sc_res   = dif[W-1:0];
                sc_carry = dif[W];
                sc_ovf   = (OP1[W-1] != OP2[W-1]) && (dif[W-1] != OP1[W-1]);
            end
            3'b010:  sc_res = OP1 & OP2;
            3'b011:  sc_res = OP1 | OP2;
            3'b100:  sc_res = OP1 ^ OP2;
            3'b101:  sc_res = {{(W-1){1'b0}}, dif[W]};
            default: sc_res = '0;
        endcase
    end

    // One iteration step; acc_hi/acc_lo hold partial product or remainder/quotient
    logic [W:0]    mul_sum, div_shift, div_diff;
    logic [W-1:0]  mul_hi_d, mul_lo_d, div_hi_d, div_lo_d, step_hi_d, step_lo_d;

    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
        mul_hi_d  = mul_sum[W:1];
        mul_lo_d  = {mul_sum[0], acc_lo_q[W-1:1]};
        div_shift = {acc_hi_q, acc_lo_q[W-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_hi_d  = div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
        div_lo_d  = {acc_lo_q[W-2:0], ~div_diff[W]};
        step_hi_d = is_div_q ? div_hi_d : mul_hi_d;
        step_lo_d = is_div_q ? div_lo_d : mul_lo_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            opb_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            div0_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (codigo == 3'b111 && OP2 == '0) begin
                            res_q    <= '1;
                            res_hi_q <= OP1;
                            zero_q   <= 1'b0;
                            carry_q  <= 1'b0;
                            ovf_q    <= 1'b0;
                            div0_q   <= 1'b1;
                            done_q   <= 1'b1;
                        end else if (codigo[2:1] == 2'b11) begin
                            state_q  <= ITER;
                            busy_q   <= 1'b1;
                            cnt_q    <= '0;
                            is_div_q <= codigo[0];
                            opb_q    <= OP2;
                            acc_hi_q <= '0;
                            acc_lo_q <= OP1;
                        end else begin
                            res_q    <= sc_res;
                            res_hi_q <= '0;
                            zero_q   <= (sc_res == '0);
                            carry_q  <= sc_carry;
                            ovf_q    <= sc_ovf;
                            div0_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    acc_hi_q <= step_hi_d;
                    acc_lo_q <= step_lo_d;
                    cnt_q    <= cnt_q + 1'b1;
                    // The final step's result is loaded directly on the W-th edge
                    if (cnt_q == CW'(W-1)) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        res_q    <= step_lo_d;
                        res_hi_q <= step_hi_d;
                        zero_q   <= is_div_q ? (step_lo_d == '0)
                                             : ({step_hi_d, step_lo_d} == '0);
                        carry_q  <= ~is_div_q && (step_hi_d != '0);
                        ovf_q    <= 1'b0;
                        div0_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res    = res_q;
    assign res_hi = res_hi_q;
    assign zero   = zero_q;
    assign carry  = carry_q;
    assign ovf    = ovf_q;
    assign div0   = div0_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed and random operations compared against an
// arithmetic reference model, plus reset, abort and busy-ignore scenarios.
module tb_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   codigo = 3'd0;
    logic [W-1:0] OP1 = '0;
    logic [W-1:0] OP2 = '0;
    logic [W-1:0] res, res_hi;
    logic         zero, carry, ovf, div0, busy, done;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] res_hi;
        logic         zero;
        logic         carry;
        logic         ovf;
        logic         div0;
    } outs_t;

    alu_seq #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .codigo(codigo),
        .OP1(OP1), .OP2(OP2), .res(res), .res_hi(res_hi),
        .zero(zero), .carry(carry), .ovf(ovf), .div0(div0),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic outs_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint ua, ub, m, sa, sb, r, hi, p;
        outs_t  o;
        o  = '0;
        ua = longint'(a);
        ub = longint'(b);
        m  = longint'(1) << W;
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        r  = 0;
        hi = 0;
        case (op)
            3'd0: begin
                r = ua + ub;
                o.carry = (r >= m);
                o.ovf = (sa + sb > m / 2 - 1) || (sa + sb < -(m / 2));
                r = r % m;
            end
            3'd1: begin
                r = (ua - ub + m) % m;
                o.carry = (ua < ub);
                o.ovf = (sa - sb > m / 2 - 1) || (sa - sb < -(m / 2));
            end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: r = (ua < ub) ? 1 : 0;
            3'd6: begin
                p  = ua * ub;
                r  = p % m;
                hi = p / m;
                o.carry = (hi != 0);
            end
            default: begin
                if (ub == 0) begin
                    r = m - 1;
                    hi = ua;
                    o.div0 = 1'b1;
                end else begin
                    r = ua / ub;
                    hi = ua % ub;
                end
            end
        endcase
        o.res    = r[W-1:0];
        o.res_hi = hi[W-1:0];
        o.zero   = (op == 3'd6) ? (r == 0 && hi == 0) : (r == 0);
        return o;
    endfunction

    function automatic outs_t cur();
        cur = {res, res_hi, zero, carry, ovf, div0};
    endfunction

    function automatic string fmt(input outs_t o);
        return $sformatf("res=%h hi=%h z=%b c=%b v=%b d0=%b",
                         o.res, o.res_hi, o.zero, o.carry, o.ovf, o.div0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait for done; lat counts edges after acceptance
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output outs_t o, output int lat, output int bcnt);
        start  = 1'b1;
        codigo = op;
        OP1    = a;
        OP2    = b;
        bcnt   = 0;
        tick();
        start  = 1'b0;
        OP1    = W'($urandom);
        OP2    = W'($urandom);
        codigo = 3'($urandom);
        lat    = 0;
        while (done !== 1'b1 && lat < 4 * W) begin
            if (busy === 1'b1) bcnt++;
            tick();
            lat++;
        end
        if (done !== 1'b1) lat = -1;
        o = cur();
        $display("op=%0d a=%0d b=%0d -> %s lat=%0d busy_cycles=%0d", op, a, b, fmt(o), lat, bcnt);
    endtask

    task automatic test_reset();
        outs_t o;
        int    lat, bcnt;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_op(3'd0, 8'd200, 8'd100, o, lat, bcnt);
        #3 rst = 1'b1;
        #1;
        n_vec++;
        if ({cur(), busy, done} !== '0) begin
            n_err++;
            $display("FAIL reset_async: got %s busy=%b done=%b, want all zero", fmt(cur()), busy, done);
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if ({cur(), busy, done} !== '0) begin
                n_err++;
                $display("FAIL reset_idle cycle %0d: got %s busy=%b done=%b, want all zero",
                         i, fmt(cur()), busy, done);
            end
        end
        $display("reset check done");
    endtask

    task automatic test_add_sub();
        logic [2:0]       ops[3];
        logic [W-1:0]     as[3];
        logic [W-1:0]     bs[3];
        logic [2*W+3:0]   ex[3];
        outs_t            o, e;
        int               lat, bcnt;
        ops = '{3'd0, 3'd1, 3'd1};
        as  = '{8'd200, 8'h80, 8'd5};
        bs  = '{8'd100, 8'h01, 8'd5};
        ex  = '{{8'd44, 8'd0, 4'b0100}, {8'h7F, 8'd0, 4'b0010}, {8'd0, 8'd0, 4'b1000}};
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], as[i], bs[i], o, lat, bcnt);
            e = ex[i];
            n_vec++;
            if (o !== e || lat != 0 || bcnt != 0) begin
                n_err++;
                $display("FAIL add_sub[%0d]: got %s lat=%0d busy=%0d, want %s lat=0 busy=0",
                         i, fmt(o), lat, bcnt, fmt(e));
            end
            tick();
            n_vec++;
            if (done !== 1'b0 || cur() !== e) begin
                n_err++;
                $display("FAIL add_sub_hold[%0d]: got done=%b %s, want done=0 %s",
                         i, done, fmt(cur()), fmt(e));
            end
        end
    endtask

    task automatic test_mul_div();
        logic [2:0]       ops[4];
        logic [W-1:0]     as[4];
        logic [W-1:0]     bs[4];
        logic [2*W+3:0]   ex[4];
        int               el[4];
        outs_t            o, e;
        int               lat, bcnt;
        ops = '{3'd6, 3'd6, 3'd7, 3'd7};
        as  = '{8'd15, 8'd200, 8'd100, 8'd100};
        bs  = '{8'd17, 8'd200, 8'd7, 8'd0};
        ex  = '{{8'hFF, 8'h00, 4'b0000}, {8'h40, 8'h9C, 4'b0100},
                {8'd14, 8'd2, 4'b0000}, {8'hFF, 8'd100, 4'b0001}};
        el  = '{W, W, W, 0};
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], o, lat, bcnt);
            e = ex[i];
            n_vec++;
            if (o !== e || lat != el[i] || bcnt != el[i] || busy !== 1'b0) begin
                n_err++;
                $display("FAIL mul_div[%0d]: got %s lat=%0d busy_cycles=%0d, want %s lat=%0d busy_cycles=%0d",
                         i, fmt(o), lat, bcnt, fmt(e), el[i], el[i]);
            end
            tick();
            n_vec++;
            if (done !== 1'b0) begin
                n_err++;
                $display("FAIL mul_div_pulse[%0d]: got done=%b, want 0", i, done);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]   op;
        logic [W-1:0] a, b;
        outs_t        o, e;
        int           lat, bcnt, el;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom);
            a  = W'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            if (op == 3'd6 && b == '0) b = W'($urandom_range(1, 255));
            e  = model(op, a, b);
            el = (op == 3'd6 || (op == 3'd7 && b != '0)) ? W : 0;
            run_op(op, a, b, o, lat, bcnt);
            n_vec++;
            if (o !== e || lat != el || bcnt != el) begin
                n_err++;
                $display("FAIL random[%0d] op=%0d a=%0d b=%0d: got %s lat=%0d, want %s lat=%0d",
                         i, op, a, b, fmt(o), lat, fmt(e), el);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]   op;
        logic [W-1:0] a, b;
        outs_t        e;
        for (int i = 0; i < 20; i++) begin
            op = 3'($urandom_range(0, 5));
            a  = W'($urandom);
            b  = W'($urandom);
            e  = model(op, a, b);
            start = 1'b1; codigo = op; OP1 = a; OP2 = b;
            tick();
            $display("b2b op=%0d a=%0d b=%0d -> done=%b %s", op, a, b, done, fmt(cur()));
            n_vec++;
            if (done !== 1'b1 || cur() !== e) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got done=%b %s, want done=1 %s",
                         i, done, fmt(cur()), fmt(e));
            end
        end
        start = 1'b0;
        tick();
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL back_to_back_end: got done=%b, want 0", done);
        end
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] a, b;
        outs_t        e;
        int           lat;
        a = W'($urandom);
        b = W'($urandom_range(1, 255));
        e = model(3'd6, a, b);
        start = 1'b1; codigo = 3'd6; OP1 = a; OP2 = b;
        tick();
        codigo = 3'd0; OP1 = W'($urandom); OP2 = W'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < 4 * W) begin
            tick();
            lat++;
        end
        start = 1'b0;
        $display("busy_ignore MUL a=%0d b=%0d -> %s lat=%0d", a, b, fmt(cur()), lat);
        n_vec++;
        if (cur() !== e || lat != W) begin
            n_err++;
            $display("FAIL busy_ignore: got %s lat=%0d, want %s lat=%0d", fmt(cur()), lat, fmt(e), W);
        end
        tick();
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || cur() !== e) begin
            n_err++;
            $display("FAIL busy_ignore_after: got done=%b busy=%b %s, want done=0 busy=0 %s",
                     done, busy, fmt(cur()), fmt(e));
        end
    endtask

    task automatic test_abort();
        outs_t o, e;
        int    lat, bcnt;
        bit    bad;
        start = 1'b1; codigo = 3'd6; OP1 = 8'd200; OP2 = 8'd200;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({cur(), busy, done} !== '0) begin
            n_err++;
            $display("FAIL abort_reset: got %s busy=%b done=%b, want all zero", fmt(cur()), busy, done);
        end
        #1 rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0 || cur() !== '0) bad = 1'b1;
        end
        $display("abort: post-reset idle window checked");
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL abort_no_done: got done=%b busy=%b %s, want idle zeros", done, busy, fmt(cur()));
        end
        run_op(3'd0, 8'd1, 8'd1, o, lat, bcnt);
        e = {8'd2, 8'd0, 4'b0000};
        n_vec++;
        if (o !== e || lat != 0) begin
            n_err++;
            $display("FAIL abort_next_add: got %s lat=%0d, want %s lat=0", fmt(o), lat, fmt(e));
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul_div();
        test_random();
        test_back_to_back();
        test_busy_ignore();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
